// File: rtl/reg_file_sb_pkg.sv
// Shared processor constants for the register file and scoreboard.
// Default datapath widths and the hard-wired zero register address.
package reg_file_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  // True when the given address names the hard-wired zero register.
  function automatic logic is_reg_zero(input logic [31:0] addr);
    return (addr == 32'(REG_ZERO));
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: address decode, optional same-cycle write bypass, and
// scoreboard-based operand ready.
module reg_file_rd_port
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned NREGS = 2**ADDR_W
) (
  input  logic [DATA_W-1:0] regs [NREGS],
  input  logic [NREGS-1:0]  pending,
  input  logic [ADDR_W-1:0] rs,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] read_data,
  output logic              ready
);

  logic rs_zero;
  logic hit;

  always_comb begin
    rs_zero = is_reg_zero(32'(rs));
    hit     = (BYPASS != 0) && we && !is_reg_zero(32'(rd)) && (rd == rs);

    read_data = regs[rs];
    if (rs_zero)
      read_data = '0;
    else if (hit)
      read_data = data_in;

    ready = rs_zero || !pending[rs] || hit;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with a pending-result scoreboard.
// Register 0 reads as zero and can never be claimed.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned NREGS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] Rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_rd,
  output logic              claim_ready,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              rs1_ready,
  output logic              rs2_ready,
  output logic [NREGS-1:0]  pending
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending_nxt;
  logic              wr_en;
  logic              claim_take;

  always_comb begin
    wr_en       = we && !is_reg_zero(32'(Rd));
    claim_ready = is_reg_zero(32'(claim_rd)) || !pending[claim_rd] ||
                  (we && (Rd == claim_rd));
    claim_take  = claim_valid && claim_ready && !is_reg_zero(32'(claim_rd));

    // Clear first so a same-register claim in this cycle wins.
    pending_nxt = pending;
    if (wr_en)
      pending_nxt[Rd] = 1'b0;
    if (claim_take)
      pending_nxt[claim_rd] = 1'b1;
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= '{default: '0};
      pending <= '0;
    end else begin
      if (wr_en)
        regs[Rd] <= data_in;
      pending <= pending_nxt;
    end
  end

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port1 (
    .regs      (regs),
    .pending   (pending),
    .rs        (Rs1),
    .we        (we),
    .rd        (Rd),
    .data_in   (data_in),
    .read_data (read_data1),
    .ready     (rs1_ready)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port2 (
    .regs      (regs),
    .pending   (pending),
    .rs        (Rs2),
    .we        (we),
    .rd        (Rd),
    .data_in   (data_in),
    .read_data (read_data2),
    .ready     (rs2_ready)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench driving a bypassing and a non-bypassing register file
// from the same stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [4:0]  Rd, Rs1, Rs2, claim_rd;
  logic        we, claim_valid;

  logic        cr_b1, cr_b0;
  logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
  logic        r1_b1, r2_b1, r1_b0, r2_b0;
  logic [31:0] pend_b1, pend_b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .data_in(data_in), .Rd(Rd), .we(we),
    .Rs1(Rs1), .Rs2(Rs2), .claim_valid(claim_valid), .claim_rd(claim_rd),
    .claim_ready(cr_b1), .read_data1(rd1_b1), .read_data2(rd2_b1),
    .rs1_ready(r1_b1), .rs2_ready(r2_b1), .pending(pend_b1)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .data_in(data_in), .Rd(Rd), .we(we),
    .Rs1(Rs1), .Rs2(Rs2), .claim_valid(claim_valid), .claim_rd(claim_rd),
    .claim_ready(cr_b0), .read_data1(rd1_b0), .read_data2(rd2_b0),
    .rs1_ready(r1_b0), .rs2_ready(r2_b0), .pending(pend_b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; claim_valid = 1'b0;
    Rd = '0; data_in = '0; claim_rd = '0;
  endtask

  initial begin
    idle();
    Rs1 = '0; Rs2 = '0;
    #2;

    // Reset overrides a simultaneous write.
    rst = 1'b1; we = 1'b1; Rd = 5'd1; data_in = 32'h55;
    step();
    idle();
    Rs1 = 5'd1; Rs2 = 5'd1; claim_rd = 5'd5;
    #1;
    chk("rst_pend_b1", pend_b1, 0);
    chk("rst_pend_b0", pend_b0, 0);
    chk("rst_rd1", rd1_b1, 0);
    chk("rst_rd2", rd2_b0, 0);
    chk("rst_rdy", {r1_b1, r2_b1, r1_b0, r2_b0}, 4'hf);
    chk("rst_claim_rdy", {cr_b1, cr_b0}, 2'b11);

    // Plain write then read.
    we = 1'b1; Rd = 5'd5; data_in = 32'hDEADBEEF;
    step();
    idle();
    Rs1 = 5'd5;
    #1;
    chk("x5_rd1_b1", rd1_b1, 32'hDEADBEEF);
    chk("x5_rd1_b0", rd1_b0, 32'hDEADBEEF);
    chk("x5_rdy", {r1_b1, r1_b0}, 2'b11);

    // Same-cycle bypass vs. no bypass.
    Rs2 = 5'd7; we = 1'b1; Rd = 5'd7; data_in = 32'h12345678;
    #1;
    chk("byp_rd2_b1", rd2_b1, 32'h12345678);
    chk("byp_rd2_b0", rd2_b0, 0);
    step();
    idle();
    #1;
    chk("post_rd2_b0", rd2_b0, 32'h12345678);

    // Claim x9.
    claim_valid = 1'b1; claim_rd = 5'd9;
    #1;
    chk("claim9_rdy", {cr_b1, cr_b0}, 2'b11);
    step();
    idle();
    Rs1 = 5'd9; claim_rd = 5'd9; claim_valid = 1'b1;
    #1;
    chk("claim9_pend", pend_b1, 32'h200);
    chk("claim9_rs1_rdy", {r1_b1, r1_b0}, 2'b00);
    chk("reclaim9_rdy", {cr_b1, cr_b0}, 2'b00);
    step();
    claim_valid = 1'b0;
    #1;
    chk("reclaim9_noeff", pend_b0, 32'h200);

    // Result write for x9.
    we = 1'b1; Rd = 5'd9; data_in = 32'hA5;
    #1;
    chk("wr9_rdy_b1", r1_b1, 1'b1);
    chk("wr9_rd1_b1", rd1_b1, 32'hA5);
    chk("wr9_rdy_b0", r1_b0, 1'b0);
    chk("wr9_rd1_b0", rd1_b0, 0);
    chk("wr9_claim_rdy", {cr_b1, cr_b0}, 2'b11);
    step();
    idle();
    #1;
    chk("wr9_pend_clr", {pend_b1, pend_b0}, 64'h0);
    chk("wr9_rd1_b0_after", rd1_b0, 32'hA5);
    chk("wr9_rdy_after", r1_b0, 1'b1);

    // Register 0 ignores writes and claims.
    we = 1'b1; Rd = 5'd0; data_in = 32'hFFFFFFFF;
    claim_valid = 1'b1; claim_rd = 5'd0; Rs1 = 5'd0;
    #1;
    chk("x0_claim_rdy", {cr_b1, cr_b0}, 2'b11);
    chk("x0_rd1_byp", rd1_b1, 0);
    step();
    idle();
    #1;
    chk("x0_rd1", {rd1_b1, rd1_b0}, 64'h0);
    chk("x0_pend", {pend_b1, pend_b0}, 64'h0);

    // Write and re-claim the same pending register: claim wins.
    claim_valid = 1'b1; claim_rd = 5'd3;
    step();
    we = 1'b1; Rd = 5'd3; data_in = 32'h33;
    claim_valid = 1'b1; claim_rd = 5'd3;
    #1;
    chk("x3_claim_rdy", {cr_b1, cr_b0}, 2'b11);
    step();
    idle();
    Rs1 = 5'd3; Rs2 = 5'd3;
    #1;
    chk("x3_rd1", rd1_b1, 32'h33);
    chk("x3_rd2", rd2_b1, 32'h33);
    chk("x3_pend", pend_b1, 32'h8);
    chk("x3_rdy_both", {r1_b1, r2_b1, r1_b0, r2_b0}, 4'h0);

    // Write and claim on different registers.
    we = 1'b1; Rd = 5'd4; data_in = 32'h44;
    claim_valid = 1'b1; claim_rd = 5'd6;
    step();
    idle();
    Rs2 = 5'd4;
    #1;
    chk("diff_pend", pend_b0, 32'h48);
    chk("diff_rd2", rd2_b0, 32'h44);

    // Outstanding claims dropped by reset.
    claim_valid = 1'b1; claim_rd = 5'd1;
    step();
    claim_rd = 5'd31;
    step();
    idle();
    #1;
    chk("multi_pend", pend_b1, 32'h8000_004A);
    rst = 1'b1; we = 1'b1; Rd = 5'd1; data_in = 32'h77;
    step();
    idle();
    Rs1 = 5'd5; Rs2 = 5'd1;
    #1;
    chk("rst2_pend", {pend_b1, pend_b0}, 64'h0);
    chk("rst2_rd1", rd1_b1, 0);
    chk("rst2_rd2", rd2_b0, 0);
    chk("rst2_rdy", {r1_b1, r2_b1, r1_b0, r2_b0}, 4'hf);

    // Ordinary write after reset.
    we = 1'b1; Rd = 5'd1; data_in = 32'h11;
    step();
    idle();
    #1;
    chk("post_rst_pend", pend_b1, 0);
    chk("post_rst_rd2", {rd2_b1, rd2_b0}, {32'h11, 32'h11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
